// File: rtl/bp_mmu_ptw.sv
// bp_mmu_ptw: Sv39 hardware page-table walker.
//
// Takes one TLB miss at a time, walks up to three page-table levels through a
// single-outstanding PTE read port, and either fills the TLB with the leaf
// entry or raises the page fault that matches the access type. A/D bits are
// never updated here: a clear A, or a clear D on a store, is a fault.
//
// Ports:
//   clk_i, reset_i (async, active-high), flush_i   clock / reset / abort walk
//   satp_ppn_i                                     root table PPN
//   miss_v_i, miss_{instr,load,store}_i, miss_vtag_i  miss request
//   ready_o                                        high only when idle
//   mem_v_o, mem_addr_o, mem_yumi_i                PTE read request
//   mem_v_i, mem_data_i                            PTE read response
//   w_v_o, w_vtag_o, w_entry_o, w_level_o          TLB fill
//   {instr,load,store}_page_fault_o                fault pulses
module bp_mmu_ptw #(
  parameter int vtag_width_p = 27,
  parameter int ptag_width_p = 44,
  parameter int paddr_width_p = 56,
  localparam int entry_width_lp = ptag_width_p + 7
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [ptag_width_p-1:0]   satp_ppn_i,
  input  logic                      miss_v_i,
  input  logic                      miss_instr_i,
  input  logic                      miss_load_i,
  input  logic                      miss_store_i,
  input  logic [vtag_width_p-1:0]   miss_vtag_i,
  output logic                      ready_o,
  output logic                      mem_v_o,
  output logic [paddr_width_p-1:0]  mem_addr_o,
  input  logic                      mem_yumi_i,
  input  logic                      mem_v_i,
  input  logic [63:0]               mem_data_i,
  output logic                      w_v_o,
  output logic [vtag_width_p-1:0]   w_vtag_o,
  output logic [entry_width_lp-1:0] w_entry_o,
  output logic [1:0]                w_level_o,
  output logic                      instr_page_fault_o,
  output logic                      load_page_fault_o,
  output logic                      store_page_fault_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_DRAIN, S_WRITE, S_FAULT
  } state_e;

  state_e                    state;
  logic [1:0]                level;
  logic [ptag_width_p-1:0]   ppn_r;
  logic [vtag_width_p-1:0]   vtag_r;
  logic                      instr_r, load_r, store_r;

  logic                      w_v_r;
  logic [vtag_width_p-1:0]   w_vtag_r;
  logic [entry_width_lp-1:0] w_entry_r;
  logic [1:0]                w_level_r;
  logic                      ipf_r, lpf_r, spf_r;

  // 9-bit VPN slice indexed by walk level (VPN[2] is the top slice).
  function automatic logic [8:0] vpn_sel(input logic [vtag_width_p-1:0] vtag,
                                         input logic [1:0] lvl);
    case (lvl)
      2'd0:    vpn_sel = vtag[8:0];
      2'd1:    vpn_sel = vtag[17:9];
      default: vpn_sel = vtag[26:18];
    endcase
  endfunction

  // Superpage leaves translate the low VPN bits straight through.
  function automatic logic [ptag_width_p-1:0] fill_ptag(input logic [ptag_width_p-1:0] ppn,
                                                        input logic [vtag_width_p-1:0] vtag,
                                                        input logic [1:0] lvl);
    case (lvl)
      2'd0:    fill_ptag = ppn;
      2'd1:    fill_ptag = {ppn[ptag_width_p-1:9], vtag[8:0]};
      default: fill_ptag = {ppn[ptag_width_p-1:18], vtag[17:0]};
    endcase
  endfunction

  function automatic logic misaligned(input logic [ptag_width_p-1:0] ppn,
                                      input logic [1:0] lvl);
    case (lvl)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = |ppn[8:0];
      default: misaligned = |ppn[17:0];
    endcase
  endfunction

  // PTE field decode
  logic                    pte_v, pte_r, pte_w, pte_x, pte_a, pte_d, pte_leaf;
  logic [ptag_width_p-1:0] pte_ppn;
  logic                    pte_fault;
  logic                    unused_pte_bits;

  assign pte_v    = mem_data_i[0];
  assign pte_r    = mem_data_i[1];
  assign pte_w    = mem_data_i[2];
  assign pte_x    = mem_data_i[3];
  assign pte_a    = mem_data_i[6];
  assign pte_d    = mem_data_i[7];
  assign pte_ppn  = mem_data_i[10 +: ptag_width_p];
  assign pte_leaf = pte_r | pte_x;
  assign unused_pte_bits = ^{mem_data_i[63:54], mem_data_i[9:8]};

  assign pte_fault = ~pte_v
                   | (~pte_r & pte_w)
                   | (~pte_leaf & (level == 2'd0))
                   | (pte_leaf & misaligned(pte_ppn, level))
                   | (pte_leaf & ~pte_a)
                   | (pte_leaf & store_r & ~pte_d);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      level     <= 2'd2;
      ppn_r     <= '0;
      vtag_r    <= '0;
      instr_r   <= 1'b0;
      load_r    <= 1'b0;
      store_r   <= 1'b0;
      w_v_r     <= 1'b0;
      w_vtag_r  <= '0;
      w_entry_r <= '0;
      w_level_r <= 2'd0;
      ipf_r     <= 1'b0;
      lpf_r     <= 1'b0;
      spf_r     <= 1'b0;
    end else begin
      // Fill strobe and fault flags are single-cycle pulses.
      w_v_r <= 1'b0;
      ipf_r <= 1'b0;
      lpf_r <= 1'b0;
      spf_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_v_i && !flush_i) begin
            vtag_r  <= miss_vtag_i;
            ppn_r   <= satp_ppn_i;
            instr_r <= miss_instr_i;
            load_r  <= miss_load_i;
            store_r <= miss_store_i;
            level   <= 2'd2;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          // An accepted request must still have its response drained.
          if (flush_i)         state <= mem_yumi_i ? S_DRAIN : S_IDLE;
          else if (mem_yumi_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush_i) begin
            state <= mem_v_i ? S_IDLE : S_DRAIN;
          end else if (mem_v_i) begin
            if (pte_fault) begin
              ipf_r <= instr_r;
              lpf_r <= load_r;
              spf_r <= store_r;
              state <= S_FAULT;
            end else if (pte_leaf) begin
              w_v_r     <= 1'b1;
              w_vtag_r  <= vtag_r;
              w_level_r <= level;
              w_entry_r <= {fill_ptag(pte_ppn, vtag_r, level), mem_data_i[7:1]};
              state     <= S_WRITE;
            end else begin
              ppn_r <= pte_ppn;
              level <= level - 2'd1;
              state <= S_SEND;
            end
          end
        end
        S_DRAIN: begin
          if (mem_v_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (state == S_IDLE);
  assign mem_v_o    = (state == S_SEND);
  assign mem_addr_o = {ppn_r, vpn_sel(vtag_r, level), 3'b000};

  // A flush in the WRITE/FAULT cycle suppresses the result.
  assign w_v_o              = w_v_r & ~flush_i;
  assign w_vtag_o           = w_vtag_r;
  assign w_entry_o          = w_entry_r;
  assign w_level_o          = w_level_r;
  assign instr_page_fault_o = ipf_r & ~flush_i;
  assign load_page_fault_o  = lpf_r & ~flush_i;
  assign store_page_fault_o = spf_r & ~flush_i;

endmodule

// File: tb/tb_bp_mmu_ptw.sv
// Directed testbench for bp_mmu_ptw. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge; each task call is one clock cycle.
module tb_bp_mmu_ptw;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [43:0] satp_ppn_i = '0;
  logic        miss_v_i = 1'b0;
  logic        miss_instr_i = 1'b0;
  logic        miss_load_i = 1'b0;
  logic        miss_store_i = 1'b0;
  logic [26:0] miss_vtag_i = '0;
  logic        ready_o;
  logic        mem_v_o;
  logic [55:0] mem_addr_o;
  logic        mem_yumi_i = 1'b0;
  logic        mem_v_i = 1'b0;
  logic [63:0] mem_data_i = '0;
  logic        w_v_o;
  logic [26:0] w_vtag_o;
  logic [50:0] w_entry_o;
  logic [1:0]  w_level_o;
  logic        instr_page_fault_o;
  logic        load_page_fault_o;
  logic        store_page_fault_o;

  int n_assert = 0;
  int n_fail = 0;

  localparam logic [7:0] FV = 8'h01, FR = 8'h02, FW = 8'h04, FX = 8'h08,
                         FA = 8'h40, FD = 8'h80;
  localparam logic [2:0] T_INSTR = 3'b100, T_LOAD = 3'b010, T_STORE = 3'b001;

  bp_mmu_ptw dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .satp_ppn_i(satp_ppn_i), .miss_v_i(miss_v_i),
    .miss_instr_i(miss_instr_i), .miss_load_i(miss_load_i),
    .miss_store_i(miss_store_i), .miss_vtag_i(miss_vtag_i),
    .ready_o(ready_o), .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o),
    .mem_yumi_i(mem_yumi_i), .mem_v_i(mem_v_i), .mem_data_i(mem_data_i),
    .w_v_o(w_v_o), .w_vtag_o(w_vtag_o), .w_entry_o(w_entry_o),
    .w_level_o(w_level_o), .instr_page_fault_o(instr_page_fault_o),
    .load_page_fault_o(load_page_fault_o), .store_page_fault_o(store_page_fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] pte(input logic [43:0] ppn, input logic [7:0] flags);
    pte = {10'd0, ppn, 2'b00, flags};
  endfunction

  function automatic logic [50:0] ent(input logic [43:0] ptag, input logic [7:0] flags);
    ent = {ptag, flags[7:1]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    miss_v_i = 1'b0;
    mem_yumi_i = 1'b0;
    mem_v_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic accept(input string tag, input logic [43:0] satp,
                        input logic [26:0] vtag, input logic [2:0] typ);
    cyc();
    miss_v_i = 1'b1;
    satp_ppn_i = satp;
    miss_vtag_i = vtag;
    {miss_instr_i, miss_load_i, miss_store_i} = typ;
    smp();
    chk({tag, ".ready"}, ready_o, 1);
  endtask

  task automatic send(input string tag, input logic [55:0] addr);
    cyc();
    mem_yumi_i = 1'b1;
    smp();
    chk({tag, ".mem_v"}, mem_v_o, 1);
    chk({tag, ".addr"}, mem_addr_o, addr);
  endtask

  task automatic resp(input string tag, input logic [63:0] data);
    cyc();
    mem_v_i = 1'b1;
    mem_data_i = data;
    smp();
    chk({tag, ".mem_v_idle"}, mem_v_o, 0);
  endtask

  task automatic expect_fill(input string tag, input logic [26:0] vtag,
                             input logic [50:0] entry, input logic [1:0] lvl);
    cyc();
    smp();
    chk({tag, ".w_v"}, w_v_o, 1);
    chk({tag, ".w_vtag"}, w_vtag_o, vtag);
    chk({tag, ".w_entry"}, w_entry_o, entry);
    chk({tag, ".w_level"}, w_level_o, lvl);
    chk({tag, ".faults"}, {instr_page_fault_o, load_page_fault_o, store_page_fault_o}, 0);
    chk({tag, ".ready"}, ready_o, 0);
  endtask

  task automatic expect_fault(input string tag, input logic [2:0] typ);
    cyc();
    smp();
    chk({tag, ".faults"}, {instr_page_fault_o, load_page_fault_o, store_page_fault_o}, typ);
    chk({tag, ".w_v"}, w_v_o, 0);
  endtask

  task automatic expect_idle(input string tag);
    cyc();
    smp();
    chk({tag, ".ready"}, ready_o, 1);
    chk({tag, ".mem_v"}, mem_v_o, 0);
    chk({tag, ".w_v"}, w_v_o, 0);
    chk({tag, ".faults"}, {instr_page_fault_o, load_page_fault_o, store_page_fault_o}, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.ready", ready_o, 1);
    chk("rst.mem_v", mem_v_o, 0);
    chk("rst.mem_addr", mem_addr_o, 0);
    chk("rst.w_v", w_v_o, 0);
    chk("rst.w_entry", w_entry_o, 0);
    chk("rst.w_level", w_level_o, 0);
    chk("rst.faults", {instr_page_fault_o, load_page_fault_o, store_page_fault_o}, 0);
    smp();
    smp();
    reset_i = 1'b0;

    // 4K walk: requests in cycles 1/3/5, fill in cycle 7
    accept("w4k.acc", 44'h80000, 27'h0403, T_LOAD);
    send("w4k.req2", 56'h80000000);
    resp("w4k.rsp2", pte(44'h80001, FV));
    send("w4k.req1", 56'h80001010);
    resp("w4k.rsp1", pte(44'h80002, FV));
    send("w4k.req0", 56'h80002018);
    resp("w4k.rsp0", pte(44'h12345, FR | FW | FA | FD | FV));
    expect_fill("w4k.fill", 27'h0403, ent(44'h12345, FR | FW | FA | FD | FV), 2'd0);
    expect_idle("w4k.done");

    // 2M superpage: VPN1=1, VPN0=0x1F
    accept("w2m.acc", 44'h80000, 27'h021F, T_LOAD);
    send("w2m.req2", 56'h80000000);
    resp("w2m.rsp2", pte(44'h80001, FV));
    send("w2m.req1", 56'h80001008);
    resp("w2m.rsp1", pte(44'h40200, FR | FX | FA | FV));
    expect_fill("w2m.fill", 27'h021F, ent(44'h4021F, FR | FX | FA | FV), 2'd1);
    expect_idle("w2m.done");

    // Misaligned 1G leaf on a load: fault in cycle 3, no fill
    accept("mis.acc", 44'h80000, 27'h0040000, T_LOAD);
    send("mis.req2", 56'h80000008);
    resp("mis.rsp2", pte(44'h00001, FR | FA | FV));
    expect_fault("mis.flt", T_LOAD);
    expect_idle("mis.done");

    // Aligned 1G store leaf with D=1, then a back-to-back store with D=0
    accept("g1.acc", 44'h80000, 27'h0012345, T_STORE);
    send("g1.req2", 56'h80000000);
    resp("g1.rsp2", pte(44'h40000, FR | FW | FA | FD | FV));
    expect_fill("g1.fill", 27'h0012345, ent(44'h52345, FR | FW | FA | FD | FV), 2'd2);
    accept("nod.acc", 44'h80000, 27'h0012345, T_STORE);
    send("nod.req2", 56'h80000000);
    resp("nod.rsp2", pte(44'h40000, FR | FW | FA | FV));
    expect_fault("nod.flt", T_STORE);
    expect_idle("nod.done");

    // Invalid PTE at level 2 on an instruction fetch
    accept("inv.acc", 44'h80000, 27'h0000001, T_INSTR);
    send("inv.req2", 56'h80000000);
    resp("inv.rsp2", 64'h0);
    expect_fault("inv.flt", T_INSTR);
    expect_idle("inv.done");

    // Leaf with A=0 faults even when otherwise valid
    accept("noa.acc", 44'h80000, 27'h0000001, T_LOAD);
    send("noa.req2", 56'h80000000);
    resp("noa.rsp2", pte(44'h40000, FR | FV));
    expect_fault("noa.flt", T_LOAD);
    expect_idle("noa.done");

    // Flush in WAIT before the response: drain and discard the late response
    accept("fw.acc", 44'h80000, 27'h0403, T_LOAD);
    send("fw.req2", 56'h80000000);
    cyc();
    flush_i = 1'b1;
    smp();
    chk("fw.wait_ready", ready_o, 0);
    cyc();
    smp();
    chk("fw.drain_ready", ready_o, 0);
    chk("fw.drain_mem_v", mem_v_o, 0);
    resp("fw.late", pte(44'h40000, FR | FA | FD | FV));
    chk("fw.late_ready", ready_o, 0);
    expect_idle("fw.done");
    expect_idle("fw.after");

    // Flush in SEND without yumi returns straight to idle
    accept("fs.acc", 44'h80000, 27'h0403, T_LOAD);
    cyc();
    flush_i = 1'b1;
    smp();
    chk("fs.mem_v", mem_v_o, 1);
    expect_idle("fs.done");

    // Miss presented together with flush in IDLE is dropped
    cyc();
    miss_v_i = 1'b1;
    miss_load_i = 1'b1;
    {miss_instr_i, miss_store_i} = 2'b00;
    flush_i = 1'b1;
    smp();
    expect_idle("fi.dropped");

    // Flush during WRITE gates the fill strobe
    accept("fwr.acc", 44'h80000, 27'h0000ABC, T_LOAD);
    send("fwr.req2", 56'h80000000);
    resp("fwr.rsp2", pte(44'hC0000, FR | FA | FV));
    cyc();
    flush_i = 1'b1;
    smp();
    chk("fwr.w_v_gated", w_v_o, 0);
    expect_idle("fwr.done");

    // Backpressure: yumi low for 5 cycles, request held stable
    accept("bp.acc", 44'h80000, 27'h0000ABC, T_LOAD);
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
      chk("bp.hold_v", mem_v_o, 1);
      chk("bp.hold_addr", mem_addr_o, 56'h80000000);
    end
    send("bp.req2", 56'h80000000);
    resp("bp.rsp2", pte(44'hC0000, FR | FA | FV));
    expect_fill("bp.fill", 27'h0000ABC, ent(44'hC0ABC, FR | FA | FV), 2'd2);
    expect_idle("bp.done");

    // Asynchronous reset while in WAIT
    accept("rw.acc", 44'h80000, 27'h0403, T_LOAD);
    send("rw.req2", 56'h80000000);
    cyc();
    #2;
    reset_i = 1'b1;
    #1;
    chk("rw.ready", ready_o, 1);
    chk("rw.mem_v", mem_v_o, 0);
    chk("rw.mem_addr", mem_addr_o, 0);
    chk("rw.w_v", w_v_o, 0);
    chk("rw.faults", {instr_page_fault_o, load_page_fault_o, store_page_fault_o}, 0);
    smp();
    smp();
    reset_i = 1'b0;
    resp("rw.stray", pte(44'h40000, FR | FA | FD | FV));
    chk("rw.stray_ready", ready_o, 1);
    expect_idle("rw.no_fill");
    expect_idle("rw.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_mmu_ptw.md
# bp_mmu_ptw

Hardware page-table walker for Sv39 translation. It accepts one TLB miss at a time from the MMU miss outputs, walks up to three levels of page table through a single-outstanding memory port, and then does one of two things. On success it returns a leaf entry to the MMU TLB write port (`w_v_i`/`w_vtag_i`/`w_entry_i`). Otherwise it reports a page fault. Accessed/dirty bits are never updated in hardware; a clear A or required D is a fault.

## Interface
Parameters:
- `vtag_width_p`, 27: virtual page number width; 3 x 9-bit VPN fields, VPN[2] at the MSBs.
- `ptag_width_p`, 44: physical page number width.
- `paddr_width_p`, 56: physical address width; must equal `ptag_width_p`+12.
- `entry_width_lp`, `ptag_width_p`+7: fill entry layout `{ptag, d, a, g, u, x, w, r}`.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: reset, asynchronous, active-high.
- `flush_i`, in, 1: abort any walk in progress.
- `satp_ppn_i`, in, `ptag_width_p`: root table PPN. Sampled when a miss is accepted.
- `miss_v_i`, in, 1: miss request valid.
- `miss_instr_i` / `miss_load_i` / `miss_store_i`, in, 1 each: access type, one-hot.
- `miss_vtag_i`, in, `vtag_width_p`: missing VPN.
- `ready_o`, out, 1: high in IDLE only.
- `mem_v_o`, out, 1: PTE read request valid.
- `mem_addr_o`, out, `paddr_width_p`: PTE address.
- `mem_yumi_i`, in, 1: request accepted this cycle.
- `mem_v_i`, in, 1: response valid. Always accepted.
- `mem_data_i`, in, 64: PTE response.
- `w_v_o`, out, 1: TLB fill strobe (one cycle).
- `w_vtag_o`, out, `vtag_width_p`: fill VPN.
- `w_entry_o`, out, `entry_width_lp`: fill leaf.
- `w_level_o`, out, 2: page size; 0 = 4K, 1 = 2M, 2 = 1G.
- `instr_page_fault_o` / `load_page_fault_o` / `store_page_fault_o`, out, 1 each: fault pulse (one cycle).

## Operation
- States: IDLE, SEND, WAIT, DRAIN, WRITE, FAULT.
- Reset (async):
  - State = IDLE; `ready_o`=1.
  - All other outputs 0.
  - Level counter = 2; PPN register and VPN register = 0.
- IDLE:
  - `miss_v_i` accepts a miss: latch vtag, type and `satp_ppn_i`; level = 2; go to SEND.
- SEND:
  - `mem_v_o`=1.
  - `mem_addr_o` = {ppn_r, vpn[level], 3'b000}, held stable until `mem_yumi_i`.
  - `mem_yumi_i` moves to WAIT.
- WAIT: on `mem_v_i`, decode the PTE: V=bit0, R=1, W=2, X=3, U=4, G=5, A=6, D=7, PPN=bits[53:10].
  - Fault if any of:
    - V=0;
    - R=0 with W=1;
    - non-leaf (R|X = 0) at level 0;
    - leaf at level>0 with PPN[9*level-1:0] != 0 (misaligned superpage);
    - leaf with A=0;
    - store leaf with D=0.
  - Non-leaf, level>0: ppn_r = PTE.PPN; level -= 1; go to SEND.
  - Valid leaf: go to WRITE.
  - Any fault: go to FAULT.
- WRITE:
  - `w_v_o`=1 with `w_level_o`=level and `w_vtag_o`=latched vtag.
  - `w_entry_o`.ptag = PTE.PPN, with the low 9*level bits replaced by the latched VPN low 9*level bits.
  - Flag bits are copied from the PTE.
  - Return to IDLE.
- FAULT: pulse the fault output matching the latched type; return to IDLE.
- Registered outputs: `w_*` and fault outputs come from registers written on the WAIT-exit edge.
- Flush:
  - IDLE: no effect; a miss presented in the same cycle is dropped.
  - SEND without `mem_yumi_i`: go to IDLE.
  - SEND with `mem_yumi_i`: go to DRAIN.
  - WAIT without `mem_v_i`: go to DRAIN.
  - WAIT with `mem_v_i`: go to IDLE, response discarded.
  - DRAIN: waits for `mem_v_i`, discards it, goes to IDLE. Flush in DRAIN has no additional effect.
  - WRITE/FAULT: `w_v_o` and the fault pulses are gated off by `flush_i`; go to IDLE.
- At most one memory request is outstanding at any time.

## Timing
- `ready_o` = (state==IDLE). Acceptance takes effect on the same edge.
- `mem_v_o` rises one cycle after acceptance, or one cycle after a non-leaf response.
- Best-case walk (yumi in the same cycle as request, response the next cycle):
  - Acceptance at cycle 0.
  - 3-level walk: requests at cycles 1/3/5, `w_v_o` at cycle 7.
  - 1G leaf: `w_v_o` at cycle 3.
  - Level-2 fault: fault pulse at cycle 3.
- `ready_o` returns high the cycle after WRITE or FAULT. A back-to-back miss may be accepted in that cycle.
- `mem_data_i` is only sampled when `mem_v_i` is high in WAIT. Responses arriving in DRAIN are discarded.
- `mem_v_i` in IDLE, SEND, WRITE or FAULT is a protocol error; the block ignores it.

## Test plan
- **4K walk:**
  - Stimulus: satp_ppn=0x80000, vtag=0x0_0403 (VPN2=0, VPN1=2, VPN0=3). Responses: non-leaf PPN 0x80001, non-leaf PPN 0x80002, leaf PPN 0x12345 with R,W,A,D,V set.
  - Required: request addresses 0x80000000, 0x80001010, 0x80002018. Then `w_v_o` at cycle 7, ptag 0x12345, level 0.
- **2M superpage:**
  - Stimulus: level-1 leaf PPN 0x40200 with R,X,A,V set, vtag VPN0=0x1F.
  - Required: `w_level_o`=1, ptag 0x4021F.
- **Faults:**
  - Misaligned 1G leaf (PPN 0x00001) -> `load_page_fault_o` pulse, `w_v_o` stays 0.
  - Store to a leaf with D=0 -> `store_page_fault_o`.
  - V=0 at level 2 for an instr miss -> `instr_page_fault_o` at cycle 3.
- **Flush in WAIT** before the response:
  - Required: state DRAIN, `ready_o`=0; the late response is discarded with no fill and no fault; `ready_o`=1 the next cycle.
- **Backpressure:**
  - Stimulus: `mem_yumi_i` held low for 5 cycles.
  - Required: `mem_v_o` and `mem_addr_o` stable throughout; walk completes normally.
- **Reset mid-walk:**
  - Stimulus: assert `reset_i` asynchronously in WAIT.
  - Required: all outputs 0 immediately, `ready_o`=1, no fill after release.
